// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer tree: one 2:1 selection level per register stage,
// with a valid/ready handshake and a single global advance enable.
module mux_tree_pipe #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [(2**SEL_W)*DATA_W-1:0]    in_data,
    input  logic [SEL_W-1:0]                in_sel,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [DATA_W-1:0]               out_data,
    output logic [SEL_W-1:0]                out_sel,
    output logic                            out_valid,
    input  logic                            out_ready
);

    localparam int N     = 2**SEL_W;
    localparam int NODES = N - 1;

    // All levels share one flat node vector; level l starts at node N - N/2**l.
    function automatic int lvl_base(input int l);
        return N - (N >> l);
    endfunction

    logic [NODES*DATA_W-1:0] node_p;
    logic [NODES*DATA_W-1:0] node_d;
    logic [SEL_W-1:0]        sel_p [SEL_W];
    logic [SEL_W-1:0]        vld_p;
    logic                    en;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    always_comb begin
        node_d = node_p;
        for (int j = 0; j < N/2; j++) begin
            node_d[j*DATA_W +: DATA_W] = in_sel[0] ? in_data[(2*j+1)*DATA_W +: DATA_W]
                                                   : in_data[(2*j)*DATA_W +: DATA_W];
        end
        // Each later level uses the select value that travelled with its operands.
        for (int l = 1; l < SEL_W; l++) begin
            for (int j = 0; j < (N >> (l+1)); j++) begin
                node_d[(lvl_base(l)+j)*DATA_W +: DATA_W] =
                    sel_p[l-1][l] ? node_p[(lvl_base(l-1)+2*j+1)*DATA_W +: DATA_W]
                                  : node_p[(lvl_base(l-1)+2*j)*DATA_W +: DATA_W];
            end
        end
    end

    // Stage boundary: every level registers its results, select and valid together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            node_p <= '0;
            vld_p  <= '0;
            for (int l = 0; l < SEL_W; l++) begin
                sel_p[l] <= '0;
            end
        end else if (en) begin
            node_p   <= node_d;
            sel_p[0] <= in_sel;
            vld_p[0] <= in_valid;
            for (int l = 1; l < SEL_W; l++) begin
                sel_p[l] <= sel_p[l-1];
                vld_p[l] <= vld_p[l-1];
            end
        end
    end

    assign out_data  = node_p[(NODES-1)*DATA_W +: DATA_W];
    assign out_sel   = sel_p[SEL_W-1];
    assign out_valid = vld_p[SEL_W-1];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three configurations (8/3, 8/1, 16/4) against a
// slot-shift reference model, plus literal expectations on the 8/3 instance.
module tb_mux_tree_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [63:0]  din0;
    logic [15:0]  din1;
    logic [255:0] din2;
    logic [2:0]   s0;
    logic [0:0]   s1;
    logic [3:0]   s2;
    logic [2:0]   vin, ordy, irdy, ovld;
    logic [7:0]   od0, od1;
    logic [15:0]  od2;
    logic [2:0]   os0;
    logic [0:0]   os1;
    logic [3:0]   os2;

    mux_tree_pipe #(.DATA_W(8), .SEL_W(3)) u0 (
        .clk(clk), .rst_n(rst_n), .in_data(din0), .in_sel(s0), .in_valid(vin[0]),
        .in_ready(irdy[0]), .out_data(od0), .out_sel(os0), .out_valid(ovld[0]),
        .out_ready(ordy[0]));
    mux_tree_pipe #(.DATA_W(8), .SEL_W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_data(din1), .in_sel(s1), .in_valid(vin[1]),
        .in_ready(irdy[1]), .out_data(od1), .out_sel(os1), .out_valid(ovld[1]),
        .out_ready(ordy[1]));
    mux_tree_pipe #(.DATA_W(16), .SEL_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(din2), .in_sel(s2), .in_valid(vin[2]),
        .in_ready(irdy[2]), .out_data(od2), .out_sel(os2), .out_valid(ovld[2]),
        .out_ready(ordy[2]));

    localparam int LAT [3] = '{3, 1, 4};

    logic [15:0] odw [3];
    logic [3:0]  osw [3];
    assign odw[0] = {8'h00, od0};
    assign odw[1] = {8'h00, od1};
    assign odw[2] = od2;
    assign osw[0] = {1'b0, os0};
    assign osw[1] = {3'b000, os1};
    assign osw[2] = os2;

    // Reference: a beat is just (valid, in_data[sel], sel) riding LAT slots.
    logic        mv [3][4];
    logic [15:0] md [3][4];
    logic [3:0]  ms [3][4];

    int total = 0;
    int bad   = 0;

    logic       lit_on = 1'b0;
    logic       lit_v, lit_r;
    logic [7:0] lit_d;
    logic [2:0] lit_s;
    string      lit_name;
    logic [2:0] acc;

    function automatic logic [15:0] pick(input int i);
        case (i)
            0:       return {8'h00, din0[s0*8 +: 8]};
            1:       return {8'h00, din1[s1*8 +: 8]};
            default: return din2[s2*16 +: 16];
        endcase
    endfunction

    function automatic logic [3:0] selx(input int i);
        case (i)
            0:       return {1'b0, s0};
            1:       return {3'b000, s1};
            default: return s2;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int k = 0; k < 4; k++) begin
                    mv[i][k] <= 1'b0;
                    md[i][k] <= '0;
                    ms[i][k] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (ordy[i] || !mv[i][LAT[i]-1]) begin
                    for (int k = 3; k > 0; k--) begin
                        if (k < LAT[i]) begin
                            mv[i][k] <= mv[i][k-1];
                            md[i][k] <= md[i][k-1];
                            ms[i][k] <= ms[i][k-1];
                        end
                    end
                    mv[i][0] <= vin[i];
                    md[i][0] <= pick(i);
                    ms[i][0] <= selx(i);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst_vld%0d", i), {31'b0, ovld[i]}, 32'd0);
                chk($sformatf("rst_data%0d", i), {16'b0, odw[i]}, 32'd0);
                chk($sformatf("rst_sel%0d", i), {28'b0, osw[i]}, 32'd0);
                chk($sformatf("rst_rdy%0d", i), {31'b0, irdy[i]}, 32'd1);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rdy%0d", i), {31'b0, irdy[i]},
                    {31'b0, ordy[i] | ~mv[i][LAT[i]-1]});
                chk($sformatf("vld%0d", i), {31'b0, ovld[i]}, {31'b0, mv[i][LAT[i]-1]});
                if (mv[i][LAT[i]-1]) begin
                    chk($sformatf("data%0d", i), {16'b0, odw[i]}, {16'b0, md[i][LAT[i]-1]});
                    chk($sformatf("sel%0d", i), {28'b0, osw[i]}, {28'b0, ms[i][LAT[i]-1]});
                end
            end
            if (lit_on) begin
                chk({lit_name, "_vld"}, {31'b0, ovld[0]}, {31'b0, lit_v});
                chk({lit_name, "_rdy"}, {31'b0, irdy[0]}, {31'b0, lit_r});
                if (lit_v) begin
                    chk({lit_name, "_data"}, {24'b0, od0}, {24'b0, lit_d});
                    chk({lit_name, "_sel"}, {29'b0, os0}, {29'b0, lit_s});
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        acc = vin & irdy;
        @(posedge clk);
        #1;
    endtask

    task automatic setlit(input string n, input logic v, input logic [7:0] d,
                          input logic [2:0] s, input logic r);
        lit_on   = 1'b1;
        lit_name = n;
        lit_v    = v;
        lit_d    = d;
        lit_s    = s;
        lit_r    = r;
    endtask

    localparam int         ST_S [8]  = '{0, 7, 3, 4, 1, 6, 2, 5};
    localparam logic [7:0] ST_D [8]  = '{8'h10, 8'h17, 8'h13, 8'h14, 8'h11, 8'h16, 8'h12, 8'h15};
    localparam logic       BP_V [14] = '{1,1,1,1,1,1,1,1,1,1,0,0,0,0};
    localparam int         BP_S [14] = '{6,1,4,3,3,3,3,3,0,7,0,0,0,0};
    localparam logic       BP_O [14] = '{1,1,1,0,0,0,0,1,1,1,1,1,1,1};
    localparam logic       BP_EV[14] = '{0,0,0,1,1,1,1,1,1,1,1,1,1,0};
    localparam logic [7:0] BP_ED[14] = '{8'h00, 8'h00, 8'h00, 8'h16, 8'h16, 8'h16, 8'h16,
                                         8'h16, 8'h11, 8'h14, 8'h13, 8'h10, 8'h17, 8'h00};
    localparam logic       BB_V [11] = '{1,0,1,0,0,0,0,0,0,0,0};
    localparam int         BB_S [11] = '{2,2,5,5,5,5,5,5,5,5,5};
    localparam logic       BB_EV[11] = '{0,0,0,1,1,1,1,1,0,1,0};
    localparam logic [7:0] BB_ED[11] = '{8'h00, 8'h00, 8'h00, 8'h12, 8'h12, 8'h12, 8'h12,
                                         8'h12, 8'h00, 8'h15, 8'h00};
    localparam logic       BB_ER[11] = '{1,1,1,0,0,0,0,1,1,1,1};

    initial begin
        rst_n = 1'b0;
        vin   = '0;
        ordy  = '1;
        s0 = '0; s1 = '0; s2 = '0;
        acc = '0;
        for (int k = 0; k < 8; k++) din0[k*8 +: 8] = 8'(16 + k);
        din1 = 16'h1110;
        for (int k = 0; k < 8; k++) din2[k*32 +: 32] = $urandom;
        repeat (3) tick();
        rst_n = 1'b1;

        // single beat, sel 5
        s0 = 3'd5;
        vin[0] = 1'b1;
        setlit("single", 1'b0, 8'h00, 3'd0, 1'b1);
        tick();
        vin[0] = 1'b0;
        setlit("single", 1'b0, 8'h00, 3'd0, 1'b1);
        tick();
        setlit("single", 1'b0, 8'h00, 3'd0, 1'b1);
        tick();
        setlit("single", 1'b1, 8'h15, 3'd5, 1'b1);
        tick();
        setlit("single", 1'b0, 8'h00, 3'd0, 1'b1);
        tick();

        // back-to-back stream
        for (int c = 0; c < 12; c++) begin
            vin[0] = (c < 8);
            if (c < 8) s0 = 3'(ST_S[c]);
            if (c >= 3 && c < 11) setlit("stream", 1'b1, ST_D[c-3], 3'(ST_S[c-3]), 1'b1);
            else setlit("stream", 1'b0, 8'h00, 3'd0, 1'b1);
            tick();
        end

        // four-cycle backpressure with a full pipe
        for (int c = 0; c < 14; c++) begin
            vin[0]  = BP_V[c];
            s0      = 3'(BP_S[c]);
            ordy[0] = BP_O[c];
            setlit("backp", BP_EV[c], BP_ED[c], BP_ED[c][2:0], BP_O[c]);
            tick();
        end

        // bubbles ahead of a stalled beat
        for (int c = 0; c < 11; c++) begin
            vin[0]  = BB_V[c];
            s0      = 3'(BB_S[c]);
            ordy[0] = (c >= 7);
            setlit("bubble", BB_EV[c], BB_ED[c], BB_ED[c][2:0], BB_ER[c]);
            tick();
        end
        lit_on = 1'b0;

        // randomized traffic on all three configurations
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < 3; i++) begin
                if (acc[i] || !vin[i]) begin
                    vin[i] = ($urandom % 4) != 0;
                    case (i)
                        0: begin s0 = 3'($urandom); din0 = {$urandom, $urandom}; end
                        1: begin s1 = 1'($urandom); din1 = 16'($urandom); end
                        default: begin
                            s2 = 4'($urandom);
                            for (int k = 0; k < 8; k++) din2[k*32 +: 32] = $urandom;
                        end
                    endcase
                end
                ordy[i] = ($urandom % 3) != 0;
            end
            if (cyc == 1500) begin
                #2;
                rst_n = 1'b0;
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        vin  = '0;
        ordy = '1;
        repeat (8) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
